// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle between the LEGv8 datapath (master) and pipe_hazard_ctrl (slave).
// Carries the ID/EX hazard operands, branch and halt requests, and the pipeline enable/flush controls.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rn;
  logic [4:0]       id_rm;
  logic             id_rn_used;
  logic             id_rm_used;
  logic [4:0]       ex_rd;
  logic             ex_memRead;
  logic             mem_branch_taken;
  logic             halt_req;
  logic             halt_ack;
  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rn, id_rm, id_rn_used, id_rm_used, ex_rd, ex_memRead,
           mem_branch_taken, halt_req,
    input  halt_ack, pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rn, id_rm, id_rn_used, id_rm_used, ex_rd, ex_memRead,
           mem_branch_taken, halt_req,
    output halt_ack, pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Load-use stall, taken-branch flush and drain-then-halt sequencing for the 5-stage LEGv8 pipeline.
// Define PIPE_HAZARD_PERF_EN to build the saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input logic              clk,
  input logic              reset,
  pipe_hazard_ctrl_if.slave hz
);

  localparam int            DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [DW-1:0] drain_cnt_r;
  logic [DW-1:0] drain_cnt_s;
  logic          halt_ack_r;
  logic          lu_s;
  logic          br_s;
  logic          stall_s;
  logic          pc_en_s;
  logic          if_id_en_s;
  logic          if_id_flush_s;
  logic          id_ex_flush_s;
  logic          ex_mem_flush_s;

  // X31 reads as XZR, so a load targeting it can never feed a dependent instruction
  assign lu_s    = hz.ex_memRead & (hz.ex_rd != 5'd31) &
                   ((hz.id_rn_used & (hz.id_rn == hz.ex_rd)) |
                    (hz.id_rm_used & (hz.id_rm == hz.ex_rd)));
  assign br_s    = hz.mem_branch_taken;
  assign stall_s = lu_s & ~br_s;

  // Next-state and Mealy enable/flush decode
  always_comb begin
    state_s        = state_r;
    drain_cnt_s    = drain_cnt_r;
    pc_en_s        = 1'b0;
    if_id_en_s     = 1'b0;
    if_id_flush_s  = 1'b0;
    id_ex_flush_s  = 1'b0;
    ex_mem_flush_s = 1'b0;
    case (state_r)
      RUN: begin
        if (br_s) begin
          pc_en_s        = 1'b1;
          if_id_en_s     = 1'b1;
          if_id_flush_s  = 1'b1;
          id_ex_flush_s  = 1'b1;
          ex_mem_flush_s = 1'b1;
        end else if (lu_s) begin
          id_ex_flush_s = 1'b1;
        end else begin
          pc_en_s    = 1'b1;
          if_id_en_s = 1'b1;
        end
        if (hz.halt_req && !stall_s) begin
          state_s     = DRAIN;
          drain_cnt_s = DRAIN_LOAD;
        end else begin
          state_s = RUN;
        end
      end
      DRAIN: begin
        // PC is held so the discarded IF instruction is refetched on resume
        if (br_s) begin
          pc_en_s        = 1'b1;
          if_id_en_s     = 1'b1;
          if_id_flush_s  = 1'b1;
          id_ex_flush_s  = 1'b1;
          ex_mem_flush_s = 1'b1;
        end else if (lu_s) begin
          id_ex_flush_s = 1'b1;
        end else begin
          if_id_en_s    = 1'b1;
          if_id_flush_s = 1'b1;
        end
        if (stall_s) begin
          drain_cnt_s = drain_cnt_r;
        end else if (drain_cnt_r == {DW{1'b0}}) begin
          state_s = HALTED;
        end else begin
          drain_cnt_s = drain_cnt_r - {{(DW-1){1'b0}}, 1'b1};
        end
      end
      HALTED: begin
        id_ex_flush_s = 1'b1;
        if (!hz.halt_req) begin
          state_s = RUN;
        end else begin
          state_s = HALTED;
        end
      end
      default: begin
        state_s     = RUN;
        drain_cnt_s = {DW{1'b0}};
      end
    endcase
  end

  // Outputs are forced to a frozen, fully flushed pipeline while reset is held
  always_comb begin
    if (!reset) begin
      hz.pc_en        = 1'b0;
      hz.if_id_en     = 1'b0;
      hz.if_id_flush  = 1'b1;
      hz.id_ex_flush  = 1'b1;
      hz.ex_mem_flush = 1'b1;
    end else begin
      hz.pc_en        = pc_en_s;
      hz.if_id_en     = if_id_en_s;
      hz.if_id_flush  = if_id_flush_s;
      hz.id_ex_flush  = id_ex_flush_s;
      hz.ex_mem_flush = ex_mem_flush_s;
    end
  end

  // FSM state, drain counter and registered halt acknowledge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= RUN;
      drain_cnt_r <= {DW{1'b0}};
      halt_ack_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      drain_cnt_r <= drain_cnt_s;
      halt_ack_r  <= (state_s == HALTED);
    end
  end

  assign hz.halt_ack = halt_ack_r;

`ifdef PIPE_HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Saturating performance counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (stall_s && (state_r != HALTED)) begin
        stall_cnt_r <= sat_inc(stall_cnt_r);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (br_s) begin
        flush_cnt_r <= sat_inc(flush_cnt_r);
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign hz.stall_cnt = stall_cnt_r;
  assign hz.flush_cnt = flush_cnt_r;
`else
  assign hz.stall_cnt = {CNT_W{1'b0}};
  assign hz.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a behavioural model pushes the expected outputs per cycle,
// each scenario task pops and compares them; narrow counters make saturation reachable.
module tb_pipe_hazard_ctrl;

  localparam int DC   = 4;
  localparam int CW   = 4;
  localparam int VW   = 6 + 2 * CW;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic [4:0] rn;
    logic [4:0] rm;
    logic       rnu;
    logic       rmu;
    logic [4:0] rd;
    logic       mr;
    logic       br;
    logic       hr;
  } stim_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();

  pipe_hazard_ctrl #(.DRAIN_CYCLES(DC), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [VW-1:0] sb_q[$];
  logic [VW-1:0] exp_v;
  wire  [VW-1:0] obs = {bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_flush,
                        bus.ex_mem_flush, bus.halt_ack, bus.stall_cnt, bus.flush_cnt};

  // Behavioural reference: 0 RUN, 1 DRAIN, 2 HALTED
  int   m_state = 0;
  int   m_left  = 0;
  logic m_ack   = 1'b0;
  int   m_stall = 0;
  int   m_flush = 0;

  function automatic logic m_lu();
    return bus.ex_memRead && (bus.ex_rd != 5'd31) &&
           ((bus.id_rn_used && (bus.id_rn == bus.ex_rd)) ||
            (bus.id_rm_used && (bus.id_rm == bus.ex_rd)));
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_state <= 0;
      m_left  <= 0;
      m_ack   <= 1'b0;
      m_stall <= 0;
      m_flush <= 0;
    end else begin
      if (m_state != 2 && m_lu() && !bus.mem_branch_taken && m_stall < CMAX) m_stall <= m_stall + 1;
      if (bus.mem_branch_taken && m_flush < CMAX) m_flush <= m_flush + 1;
      case (m_state)
        0: begin
          m_ack <= 1'b0;
          if (bus.halt_req && !(m_lu() && !bus.mem_branch_taken)) begin
            m_state <= 1;
            m_left  <= DC - 1;
          end
        end
        1: begin
          m_ack <= !(m_lu() && !bus.mem_branch_taken) && (m_left == 0);
          if (!(m_lu() && !bus.mem_branch_taken)) begin
            if (m_left == 0) m_state <= 2;
            else m_left <= m_left - 1;
          end
        end
        default: begin
          m_ack <= bus.halt_req;
          if (!bus.halt_req) m_state <= 0;
        end
      endcase
    end
  end

  function automatic stim_t mk(input logic [4:0] rn, input logic [4:0] rm, input logic rnu,
                               input logic rmu, input logic [4:0] rd, input logic mr,
                               input logic br, input logic hr);
    stim_t s;
    s.rn = rn; s.rm = rm; s.rnu = rnu; s.rmu = rmu; s.rd = rd; s.mr = mr; s.br = br; s.hr = hr;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    logic [4:0]    ctrl;
    logic [CW-1:0] st;
    logic [CW-1:0] fl;
    logic          ack;
    bus.id_rn = s.rn; bus.id_rm = s.rm; bus.id_rn_used = s.rnu; bus.id_rm_used = s.rmu;
    bus.ex_rd = s.rd; bus.ex_memRead = s.mr; bus.mem_branch_taken = s.br; bus.halt_req = s.hr;
    #0;
    if (!reset)                  ctrl = 5'b00111;
    else if (m_state == 2)       ctrl = 5'b00010;
    else if (s.br)               ctrl = 5'b11111;
    else if (m_lu())             ctrl = 5'b00010;
    else if (m_state == 1)       ctrl = 5'b01100;
    else                         ctrl = 5'b11000;
    ack = reset ? m_ack : 1'b0;
`ifdef PIPE_HAZARD_PERF_EN
    st = reset ? CW'(m_stall) : {CW{1'b0}};
    fl = reset ? CW'(m_flush) : {CW{1'b0}};
`else
    st = {CW{1'b0}};
    fl = {CW{1'b0}};
`endif
    sb_q.push_back({ctrl, ack, st, fl});
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      apply(mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1));
      @(negedge clk);
      n_checks++;
      exp_v = sb_q.pop_front();
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL reset[%0d] got=%b exp=%b", i, obs, exp_v);
      end
      @(posedge clk); #1;
    end
    reset = 1'b1;
  endtask

  task automatic test_load_use();
    stim_t tbl[8];
    logic [CW-1:0] want;
    tbl[0] = mk(5'd5,  5'd0,  1'b1, 1'b0, 5'd5,  1'b1, 1'b0, 1'b0);
    tbl[1] = mk(5'd5,  5'd0,  1'b1, 1'b0, 5'd5,  1'b0, 1'b0, 1'b0);
    tbl[2] = mk(5'd31, 5'd0,  1'b1, 1'b0, 5'd31, 1'b1, 1'b0, 1'b0);
    tbl[3] = mk(5'd5,  5'd0,  1'b0, 1'b0, 5'd5,  1'b1, 1'b0, 1'b0);
    tbl[4] = mk(5'd1,  5'd7,  1'b1, 1'b1, 5'd7,  1'b1, 1'b0, 1'b0);
    tbl[5] = mk(5'd1,  5'd7,  1'b1, 1'b0, 5'd7,  1'b1, 1'b0, 1'b0);
    tbl[6] = mk(5'd12, 5'd3,  1'b1, 1'b1, 5'd12, 1'b0, 1'b0, 1'b0);
    tbl[7] = mk(5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      apply(tbl[i]);
      @(negedge clk);
      n_checks++;
      exp_v = sb_q.pop_front();
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL load_use[%0d] got=%b exp=%b", i, obs, exp_v);
      end
      @(posedge clk); #1;
    end
`ifdef PIPE_HAZARD_PERF_EN
    want = 4'd2;
`else
    want = 4'd0;
`endif
    n_checks++;
    if (bus.stall_cnt !== want) begin
      n_fail++;
      $display("FAIL load_use_stall_cnt got=%0d exp=%0d", bus.stall_cnt, want);
    end
  endtask

  task automatic test_branch();
    stim_t tbl[4];
    logic [CW-1:0] want;
    tbl[0] = mk(5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
    tbl[1] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tbl[2] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    tbl[3] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      apply(tbl[i]);
      @(negedge clk);
      n_checks++;
      exp_v = sb_q.pop_front();
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL branch[%0d] got=%b exp=%b", i, obs, exp_v);
      end
      @(posedge clk); #1;
    end
`ifdef PIPE_HAZARD_PERF_EN
    want = 4'd2;
`else
    want = 4'd0;
`endif
    n_checks++;
    if (bus.flush_cnt !== want || bus.stall_cnt !== want) begin
      n_fail++;
      $display("FAIL branch_counters got=%0d/%0d exp=%0d/%0d", bus.stall_cnt, bus.flush_cnt, want, want);
    end
  endtask

  task automatic test_halt(input int lu_at, input int br_at, input int want_lat, input string nm);
    int first_ack = -1;
    for (int i = 0; i < 15; i++) begin
      apply(mk(5'd4, 5'd0, 1'b1, 1'b0, 5'd4, (i == lu_at), (i == br_at), (i < 12)));
      @(negedge clk);
      if (bus.halt_ack && first_ack < 0) first_ack = i;
      n_checks++;
      exp_v = sb_q.pop_front();
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL %s[%0d] got=%b exp=%b", nm, i, obs, exp_v);
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (first_ack != want_lat) begin
      n_fail++;
      $display("FAIL %s_latency got=%0d exp=%0d", nm, first_ack, want_lat);
    end
  endtask

  task automatic test_drain_deassert();
    int acks = 0;
    for (int i = 0; i < 12; i++) begin
      apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, (i == 0)));
      @(negedge clk);
      if (bus.halt_ack) acks++;
      n_checks++;
      exp_v = sb_q.pop_front();
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL drain_deassert[%0d] got=%b exp=%b", i, obs, exp_v);
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (acks != 1) begin
      n_fail++;
      $display("FAIL drain_deassert_ack_cycles got=%0d exp=1", acks);
    end
  endtask

  task automatic test_saturation();
    logic [CW-1:0] want;
    for (int i = 0; i < 40; i++) begin
      apply(mk(5'd6, 5'd0, 1'b1, 1'b0, 5'd6, (i >= 20), (i < 20), 1'b0));
      @(negedge clk);
      n_checks++;
      exp_v = sb_q.pop_front();
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL saturation[%0d] got=%b exp=%b", i, obs, exp_v);
      end
      @(posedge clk); #1;
    end
`ifdef PIPE_HAZARD_PERF_EN
    want = 4'hF;
`else
    want = 4'h0;
`endif
    n_checks++;
    if (bus.flush_cnt !== want || bus.stall_cnt !== want) begin
      n_fail++;
      $display("FAIL saturation_final got=%0d/%0d exp=%0d/%0d", bus.stall_cnt, bus.flush_cnt, want, want);
    end
  endtask

  task automatic test_reset_mid_drain();
    for (int i = 0; i < 7; i++) begin
      if (i == 2) reset = 1'b0;
      if (i == 4) reset = 1'b1;
      apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, (i < 4)));
      if (i == 2) #1;
      else @(negedge clk);
      n_checks++;
      exp_v = sb_q.pop_front();
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL reset_mid_drain[%0d] got=%b exp=%b", i, obs, exp_v);
      end
      if (i == 2) @(negedge clk);
      @(posedge clk); #1;
    end
    n_checks++;
    if (bus.halt_ack !== 1'b0 || bus.pc_en !== 1'b1 || bus.stall_cnt !== 4'd0 || bus.flush_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_mid_drain_final got=ack%b pc%b s%0d f%0d exp=ack0 pc1 s0 f0",
               bus.halt_ack, bus.pc_en, bus.stall_cnt, bus.flush_cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_branch();
    test_halt(-1, -1, DC + 1, "halt");
    test_halt(1, 3, DC + 2, "halt_lu");
    test_drain_deassert();
    test_saturation();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and pipeline-sequencing controller for the 5-stage pipelined ARM (LEGv8) processor. Sits beside the datapath and drives the enable/flush controls of the PC and the IF/ID, ID/EX and EX/MEM pipeline registers. It handles three conditions: load-use stalls, taken-branch flushes, and an externally requested halt. A halt drains all in-flight instructions before acknowledging, so data memory can be dumped from a quiescent core.

## Interface
- `DRAIN_CYCLES`, default 4: cycles needed for the instruction in ID to retire through WB.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk`  in  1  processor clock (CLOCK_50 at top level).
- `reset`  in  1  asynchronous, active-low reset.
- `id_rn`  in  5  source register 1 of the instruction in ID.
- `id_rm`  in  5  source register 2 of the instruction in ID.
- `id_rn_used`  in  1  the ID instruction reads `id_rn`.
- `id_rm_used`  in  1  the ID instruction reads `id_rm`.
- `ex_rd`  in  5  destination register of the instruction in EX.
- `ex_memRead`  in  1  the instruction in EX is a load.
- `mem_branch_taken`  in  1  branch resolved taken in MEM this cycle.
- `halt_req`  in  1  level request to freeze the pipeline.
- `halt_ack`  out  1  registered; high while the pipeline is drained and frozen.
- `pc_en`  out  1  PC load enable.
- `if_id_en`  out  1  IF/ID register enable.
- `if_id_flush`  out  1  load a NOP into IF/ID.
- `id_ex_flush`  out  1  load a bubble (all control bits 0) into ID/EX.
- `ex_mem_flush`  out  1  load a bubble into EX/MEM.
- `stall_cnt`  out  CNT_W  load-use stall cycles.
- `flush_cnt`  out  CNT_W  taken-branch flushes.

## Operation
- **Load-use hazard (`lu`)** is `ex_memRead & ex_rd!=31 & ((id_rn_used & id_rn==ex_rd) | (id_rm_used & id_rm==ex_rd))`.
  - X31/XZR never causes a hazard.
- **Branch (`br`)** is `mem_branch_taken`. It has priority over `lu`.
- **FSM states:** RUN, DRAIN, HALTED. The reset state is RUN.
- **RUN:**
  - If `br`: `pc_en=1`, `if_id_en=1`, `if_id_flush=1`, `id_ex_flush=1`, `ex_mem_flush=1`.
  - Else if `lu`: `pc_en=0`, `if_id_en=0`, `id_ex_flush=1`, other flushes 0.
  - Else: `pc_en=1`, `if_id_en=1`, all flushes 0.
  - If `halt_req=1` and not `lu`: go to DRAIN and load `drain_cnt=DRAIN_CYCLES-1`.
  - If `halt_req=1` and `lu`: stay in RUN; the request is accepted on the first cycle without `lu`.
- **DRAIN:**
  - Defaults: `pc_en=0`, `if_id_en=1`, `if_id_flush=1`. The instruction in IF is discarded, and the held PC refetches it on resume.
  - If `br`: `pc_en=1` so the PC captures the target; `id_ex_flush=1`, `ex_mem_flush=1`; `drain_cnt` still decrements.
  - If `lu`: same outputs as RUN `lu`; `drain_cnt` holds.
  - When `drain_cnt==0` and there is no `lu`: go to HALTED. Otherwise decrement.
- **HALTED:**
  - Outputs: `pc_en=0`, `if_id_en=0`, `id_ex_flush=1`, `ex_mem_flush=0`, `halt_ack=1`.
  - If `halt_req=0`: go to RUN.
- **Deassertion during DRAIN:** if `halt_req` drops during DRAIN, the drain still completes. HALTED is entered, `halt_ack` pulses for exactly one cycle, then the FSM returns to RUN.
- **Counters:**
  - `stall_cnt` increments on every cycle where `lu` causes a stall (RUN or DRAIN).
  - `flush_cnt` increments on every cycle with `br`.
  - Both saturate at all-ones and never wrap.

## Timing
- Enable/flush outputs are combinational (Mealy) from the registered state plus current inputs, with zero-cycle latency. They must settle before the clock edge that captures the pipeline registers.
- `halt_ack` and the counters are registered.
- Minimum `halt_req`→`halt_ack` latency is DRAIN_CYCLES+1 edges; each `lu` cycle during DRAIN adds one.
- `halt_ack` falls on the edge after `halt_req` is sampled low.
- Reset (asynchronous on falling `reset`, held while low):
  - state RUN, `drain_cnt=0`, `halt_ack=0`, counters 0.
  - Outputs forced to `pc_en=0`, `if_id_en=0`, `if_id_flush=1`, `id_ex_flush=1`, `ex_mem_flush=1`.
- Reset mid-DRAIN or mid-HALTED aborts the sequence. The FSM is in RUN after reset releases.

## Configuration
- `PIPE_HAZARD_PERF_EN`:
  - Defined: the `stall_cnt`/`flush_cnt` registers and saturating incrementers are built.
  - Undefined: both outputs are constant 0 and no counter flops are synthesized. FSM and control behaviour are identical in both cases.

## Test plan
- `ex_memRead=1`, `ex_rd=5`, `id_rn=5`, `id_rn_used=1` for one cycle → `pc_en=0`, `if_id_en=0`, `id_ex_flush=1` that cycle; `stall_cnt` goes 0→1.
- Same as above but `ex_rd=31`, and again with `id_rn_used=0` → no stall; `pc_en=1`, all flushes 0.
- `mem_branch_taken=1` together with a load-use match → branch wins: `pc_en=1`, all three flushes 1; `flush_cnt` +1, `stall_cnt` unchanged.
- `halt_req` raised in RUN with no hazards → `halt_ack` rises exactly 5 edges later; `pc_en=0` from the first DRAIN cycle. Drop `halt_req` → back in RUN with `pc_en=1` one edge later.
- `halt_req` with one `lu` cycle inside DRAIN → `halt_ack` is delayed to 6 edges. A `br` during DRAIN gives `pc_en=1` for that cycle only.
- Drive `reset` low while in DRAIN → outputs take reset values immediately; after release the FSM is in RUN with `halt_ack=0` and counters 0. With `PIPE_HAZARD_PERF_EN` undefined, counters read 0 throughout.
